// File: rtl/spi_target_port_pkg.sv
// Shared constants for the SPI target port: command bytes, fill byte, FSM encoding.
// SPITGT_AUTOINC_EN selects burst address increment; otherwise the address is held per frame.
package spi_target_port_pkg;

  localparam logic [7:0] SPITGT_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPITGT_CMD_READ  = 8'h03;
  localparam logic [7:0] SPITGT_FILL      = 8'hFF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  function automatic logic [7:0] spitgt_next_addr(input logic [7:0] addr);
`ifdef SPITGT_AUTOINC_EN
    return addr + 8'd1;
`else
    return addr;
`endif
  endfunction

endpackage

// File: rtl/spi_target_port_in_sync.sv
// Synchronizer for the SPI pad inputs plus edge pulses for sclk and cs_n.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cs_n,
  input  logic i_sclk,
  input  logic i_mosi,
  output logic o_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_rise,
  output logic o_cs_fall
);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_cs_prev;
  logic                   r_sclk_prev;
  logic                   w_cs;
  logic                   w_sclk;

  // cs_n resets low so that a select held across reset never fakes a falling edge;
  // a new frame needs cs_n to be seen high first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync   <= '0;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_prev   <= 1'b0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_cs_prev   <= w_cs;
      r_sclk_prev <= w_sclk;
    end
  end

  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign o_sclk_rise = w_sclk & ~r_sclk_prev;
  assign o_sclk_fall = ~w_sclk & r_sclk_prev;
  assign o_cs_rise   = w_cs & ~r_cs_prev;
  assign o_cs_fall   = ~w_cs & r_cs_prev;

endmodule

// File: rtl/spi_target_port.sv
// SPI mode-0 target giving an external controller read/write access to the register file.
// Define SPITGT_AUTOINC_EN for burst address increment after each data byte.
module spi_target_port
  import spi_target_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_dout,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_din,
  output logic       busy
);

  logic       w_mosi;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_rise;
  logic       w_cs_fall;
  logic       w_active;
  logic       w_byte_done;
  logic [7:0] w_byte;

  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx;
  logic [7:0] r_tx;
  logic [7:0] r_tx_buf;
  logic [7:0] r_addr;
  logic       r_is_rd;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_dout;
  logic       r_reg_wr;
  logic       r_reg_rd;
  logic       r_rd_d1;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cs_n     (spi_cs_n),
    .i_sclk     (spi_sclk),
    .i_mosi     (spi_mosi),
    .o_mosi     (w_mosi),
    .o_sclk_rise(w_sclk_rise),
    .o_sclk_fall(w_sclk_fall),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall)
  );

  assign w_active    = (r_state != ST_IDLE);
  assign w_byte      = {r_rx[6:0], w_mosi};
  assign w_byte_done = w_active & ~w_cs_rise & w_sclk_rise & (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx       <= 8'h00;
      r_tx       <= SPITGT_FILL;
      r_tx_buf   <= SPITGT_FILL;
      r_addr     <= 8'h00;
      r_is_rd    <= 1'b0;
      r_reg_addr <= 8'h00;
      r_reg_dout <= 8'h00;
      r_reg_wr   <= 1'b0;
      r_reg_rd   <= 1'b0;
      r_rd_d1    <= 1'b0;
    end else begin
      r_reg_wr <= 1'b0;
      r_reg_rd <= 1'b0;
      r_rd_d1  <= r_reg_rd;
      if (r_rd_d1) begin
        r_tx_buf <= reg_din;
      end
      if (w_cs_rise) begin
        // Any partial byte is dropped here; no strobe can follow.
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_tx      <= SPITGT_FILL;
      end else if (!w_active) begin
        if (w_cs_fall) begin
          r_state   <= ST_CMD;
          r_bit_cnt <= 3'd0;
          r_tx      <= SPITGT_FILL;
        end
      end else begin
        if (w_sclk_rise) begin
          r_rx      <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        // The fall after the 8th rise (counter wrapped to 0) starts the next byte.
        if (w_sclk_fall) begin
          if (r_bit_cnt == 3'd0) begin
            r_tx <= (r_state == ST_RDATA) ? r_tx_buf : SPITGT_FILL;
          end else begin
            r_tx <= {r_tx[6:0], 1'b1};
          end
        end
        if (w_byte_done) begin
          case (r_state)
            ST_CMD: begin
              if (w_byte == SPITGT_CMD_WRITE) begin
                r_state <= ST_ADDR;
                r_is_rd <= 1'b0;
              end else if (w_byte == SPITGT_CMD_READ) begin
                r_state <= ST_ADDR;
                r_is_rd <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
            ST_ADDR: begin
              if (r_is_rd) begin
                r_state    <= ST_RDATA;
                r_reg_addr <= w_byte;
                r_reg_rd   <= 1'b1;
                r_addr     <= spitgt_next_addr(w_byte);
              end else begin
                r_state <= ST_WDATA;
                r_addr  <= w_byte;
              end
            end
            ST_WDATA: begin
              r_reg_addr <= r_addr;
              r_reg_dout <= w_byte;
              r_reg_wr   <= 1'b1;
              r_addr     <= spitgt_next_addr(r_addr);
            end
            ST_RDATA: begin
              r_reg_addr <= r_addr;
              r_reg_rd   <= 1'b1;
              r_addr     <= spitgt_next_addr(r_addr);
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign spi_miso    = r_tx[7];
  assign spi_miso_oe = w_active;
  assign busy        = w_active;
  assign reg_addr    = r_reg_addr;
  assign reg_dout    = r_reg_dout;
  assign reg_wr      = r_reg_wr;
  assign reg_rd      = r_reg_rd;

endmodule

// File: tb/tb_spi_target_port.sv
// Scoreboard bench for spi_target_port: directed SPI frames, strobes checked by a monitor.
module tb_spi_target_port;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic [7:0] reg_din = 8'h00;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_dout;
  logic       reg_wr;
  logic       reg_rd;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];

  spi_target_port #(
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .reg_addr   (reg_addr),
    .reg_dout   (reg_dout),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_din    (reg_din),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Register file model: each register reads back its own address.
  always @(posedge clk) begin
    if (reg_rd) reg_din <= reg_addr;
  end

  always @(negedge clk) begin
    if (reg_wr && reg_rd) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap: got wr=1 rd=1, required at most one");
    end
    if (reg_wr) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr: got addr=%h data=%h, required no write", reg_addr, reg_dout);
      end else begin
        logic [15:0] e;
        e = exp_wr_q.pop_front();
        if ({reg_addr, reg_dout} !== e) begin
          errors++;
          $display("FAIL wr_access: got addr=%h data=%h, required addr=%h data=%h",
                   reg_addr, reg_dout, e[15:8], e[7:0]);
        end
      end
    end
    if (reg_rd) begin
      checks++;
      if (exp_rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd: got addr=%h, required no read", reg_addr);
      end else begin
        logic [7:0] e;
        e = exp_rd_q.pop_front();
        if (reg_addr !== e) begin
          errors++;
          $display("FAIL rd_addr: got %h, required %h", reg_addr, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] exp_miso, input int nbits = 8);
    logic [7:0] rx;
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      clk_wait(HALF);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      clk_wait(HALF);
      spi_sclk = 1'b0;
    end
    if (nbits == 8) check("miso_byte", 32'(rx), 32'(exp_miso));
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    clk_wait(2 * HALF);
    check("busy_in_frame", 32'(busy), 32'd1);
    check("oe_in_frame", 32'(spi_miso_oe), 32'd1);
  endtask

  task automatic frame_end();
    clk_wait(HALF);
    spi_cs_n = 1'b1;
    clk_wait(SYNC_STAGES + 3);
    check("busy_after_cs", 32'(busy), 32'd0);
    check("oe_after_cs", 32'(spi_miso_oe), 32'd0);
    check("wr_pending", 32'(exp_wr_q.size()), 32'd0);
    check("rd_pending", 32'(exp_rd_q.size()), 32'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
    clk_wait(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, required finish within 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    clk_wait(4);
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'h00);
    check("rst_reg_dout", 32'(reg_dout), 32'h00);
    check("rst_wr_rd", 32'({reg_wr, reg_rd}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    clk_wait(6);

    // Single write.
    exp_wr_q.push_back({8'h0B, 8'h5A});
    frame_start();
    xfer(8'h02, 8'hFF);
    xfer(8'h0B, 8'hFF);
    xfer(8'h5A, 8'hFF);
    frame_end();

    // Read burst starting at FE.
`ifdef SPITGT_AUTOINC_EN
    exp_rd_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
`else
    exp_rd_q = '{8'hFE, 8'hFE, 8'hFE, 8'hFE};
`endif
    frame_start();
    xfer(8'h03, 8'hFF);
    xfer(8'hFE, 8'hFF);
    xfer(8'h00, 8'hFE);
`ifdef SPITGT_AUTOINC_EN
    xfer(8'h00, 8'hFF);
    xfer(8'h00, 8'h00);
`else
    xfer(8'h00, 8'hFE);
    xfer(8'h00, 8'hFE);
`endif
    frame_end();

    // Write burst of two bytes.
    exp_wr_q.push_back({8'h40, 8'h11});
`ifdef SPITGT_AUTOINC_EN
    exp_wr_q.push_back({8'h41, 8'h22});
`else
    exp_wr_q.push_back({8'h40, 8'h22});
`endif
    frame_start();
    xfer(8'h02, 8'hFF);
    xfer(8'h40, 8'hFF);
    xfer(8'h11, 8'hFF);
    xfer(8'h22, 8'hFF);
    frame_end();

    // Unknown command: no strobes, fill only.
    frame_start();
    xfer(8'h9F, 8'hFF);
    xfer(8'h00, 8'hFF);
    xfer(8'h00, 8'hFF);
    frame_end();

    // Abort mid-byte, then a clean write to the same register.
    frame_start();
    xfer(8'h02, 8'hFF);
    xfer(8'h10, 8'hFF);
    xfer(8'hA5, 8'hFF, 5);
    frame_end();
    exp_wr_q.push_back({8'h10, 8'h33});
    frame_start();
    xfer(8'h02, 8'hFF);
    xfer(8'h10, 8'hFF);
    xfer(8'h33, 8'hFF);
    frame_end();

    // Reset during a read data byte, select held low across it.
    exp_rd_q.push_back(8'h20);
    frame_start();
    xfer(8'h03, 8'hFF);
    xfer(8'h20, 8'hFF);
    xfer(8'h00, 8'h00, 3);
    rst_n = 1'b0;
    #1;
    check("rstmid_oe", 32'(spi_miso_oe), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_miso", 32'(spi_miso), 32'd1);
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(4);
    xfer(8'h02, 8'hFF);
    xfer(8'h55, 8'hFF);
    check("rstmid_busy_after", 32'(busy), 32'd0);
    frame_end();
    exp_wr_q.push_back({8'h21, 8'h77});
    frame_start();
    xfer(8'h02, 8'hFF);
    xfer(8'h21, 8'hFF);
    xfer(8'h77, 8'hFF);
    frame_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
